// File: rtl/cim_ctrl_pkg.sv
// Shared encodings for the CIM macro command sequencer: command opcodes,
// controller state codes and the idle levels of the macro control pins.
package cim_ctrl_pkg;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_COMPUTE = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_COMPUTE   = 3'd2;
    localparam logic [2:0] ST_CLEAR     = 3'd3;
    localparam logic [2:0] ST_READ_SEL  = 3'd4;
    localparam logic [2:0] ST_READ_WAIT = 3'd5;
    localparam logic [2:0] ST_READ_OUT  = 3'd6;

    // Macro pin levels whenever no write/compute/clear is in progress.
    localparam logic CS_IDLE       = 1'b1;
    localparam logic WEB_IDLE      = 1'b0;
    localparam logic CIMEB_IDLE    = 1'b1;
    localparam logic PSUM_EB_IDLE  = 1'b0;
    localparam logic RST_OREG_IDLE = 1'b0;

endpackage

// File: rtl/cim_ctrl_readout.sv
// READ sequencing for the CIM controller: walks the output registers,
// waits out the macro read latency and holds each result until accepted.
module cim_ctrl_readout
    import cim_ctrl_pkg::*;
#(
    parameter int NUM_OUT  = 8,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  state_t      state,
    input  logic        dout_ready,
    input  logic [31:0] cim_cim_output,
    output state_t      read_next,
    output logic [3:0]  sel,
    output logic        dout_valid,
    output logic [31:0] dout_data,
    output logic        dout_last
);

    localparam logic [3:0] LAST_SEL  = 4'(NUM_OUT - 1);
    localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

    logic [3:0] k;
    logic [1:0] wait_cnt;
    logic       last_sel;

    assign last_sel = (k == LAST_SEL);
    // The select is held in k for the whole SEL/WAIT/OUT span of one output.
    assign sel = k;

    always_comb begin
        read_next = ST_IDLE;
        case (state)
            ST_READ_SEL:  read_next = ST_READ_WAIT;
            ST_READ_WAIT: read_next = (wait_cnt == LAST_WAIT) ? ST_READ_OUT : ST_READ_WAIT;
            ST_READ_OUT: begin
                if (dout_ready)
                    read_next = last_sel ? ST_IDLE : ST_READ_SEL;
                else
                    read_next = ST_READ_OUT;
            end
            default:      read_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            wait_cnt   <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                ST_READ_SEL: wait_cnt <= '0;
                ST_READ_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        dout_valid <= 1'b1;
                        dout_data  <= cim_cim_output;
                        dout_last  <= last_sel;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_READ_OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        k          <= last_sel ? 4'd0 : k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cim_controller.sv
// Command-driven initiator for one Basic_GeMM_CIM macro (LOAD/COMPUTE/READ/CLEAR).
// Optional performance counters are built when CIM_CTRL_PERF_EN is defined.
module cim_controller
    import cim_ctrl_pkg::*;
#(
    parameter int NUM_OUT  = 8,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic        dout_last,
    output logic        busy,
    output logic        cim_cs,
    output logic        cim_web,
    output logic        cim_cimeb,
    output logic        cim_partial_sum_eb,
    output logic        cim_reset_output_reg,
    output logic [3:0]  cim_output_reg,
    output logic [31:0] cim_address,
    output logic [31:0] cim_input_data,
`ifdef CIM_CTRL_PERF_EN
    output logic [31:0] perf_busy,
    output logic [31:0] perf_stall,
`endif
    input  logic [31:0] cim_cim_output
);

    state_t      state;
    state_t      state_next;
    state_t      read_next;
    logic [31:0] addr_q;
    logic [7:0]  remain_q;
    logic        cmd_fire;
    logic        in_stream;
    logic        beat;
    logic        load_beat;
    logic        comp_beat;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_stream = (state == ST_LOAD) || (state == ST_COMPUTE);
    assign din_ready = in_stream && (remain_q != 8'd0);
    assign beat      = din_valid && din_ready;
    assign load_beat = beat && (state == ST_LOAD);
    assign comp_beat = beat && (state == ST_COMPUTE);

    // Macro pins follow the din handshake combinationally; idle levels otherwise.
    assign cim_cs               = CS_IDLE;
    assign cim_web              = load_beat ? 1'b1 : WEB_IDLE;
    assign cim_cimeb            = comp_beat ? 1'b0 : CIMEB_IDLE;
    assign cim_partial_sum_eb   = comp_beat ? 1'b1 : PSUM_EB_IDLE;
    assign cim_reset_output_reg = (state == ST_CLEAR) ? 1'b1 : RST_OREG_IDLE;
    assign cim_address          = beat ? addr_q : 32'd0;
    assign cim_input_data       = beat ? din_data : 32'd0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD:    state_next = ST_LOAD;
                        OP_COMPUTE: state_next = ST_COMPUTE;
                        OP_READ:    state_next = ST_READ_SEL;
                        default:    state_next = ST_CLEAR;
                    endcase
                end
            end
            ST_LOAD, ST_COMPUTE: begin
                // A zero-length command spends exactly one cycle here.
                if ((remain_q == 8'd0) || (beat && remain_q == 8'd1))
                    state_next = ST_IDLE;
            end
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = read_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state <= state_next;
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_len;
            end else if (beat) begin
                remain_q <= remain_q - 8'd1;
                if (state == ST_LOAD)
                    addr_q <= addr_q + 32'd4;
            end
        end
    end

    cim_ctrl_readout #(
        .NUM_OUT  (NUM_OUT),
        .READ_LAT (READ_LAT)
    ) u_readout (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .dout_ready     (dout_ready),
        .cim_cim_output (cim_cim_output),
        .read_next      (read_next),
        .sel            (cim_output_reg),
        .dout_valid     (dout_valid),
        .dout_data      (dout_data),
        .dout_last      (dout_last)
    );

`ifdef CIM_CTRL_PERF_EN
    logic stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    assign stall = (in_stream && !beat) ||
                   ((state == ST_READ_OUT) && dout_valid && !dout_ready);

    always_ff @(posedge clk) begin
        if (rst || state == ST_CLEAR) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            perf_busy  <= sat_inc(perf_busy, busy);
            perf_stall <= sat_inc(perf_stall, stall);
        end
    end
`endif

endmodule

// File: tb/tb_cim_controller.sv
// Self-checking bench for cim_controller with a behavioural macro stub
// whose selected output register reads back as 0xA0 + select.
module tb_cim_controller;
    import cim_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        busy;
    logic        cim_cs, cim_web, cim_cimeb, cim_partial_sum_eb, cim_reset_output_reg;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_cim_output;
    logic [31:0] stub_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wr_q[$];
    logic [32:0] rd_q[$];

    always #5 clk = ~clk;

    // Macro stub with one cycle of read latency.
    always_ff @(posedge clk) stub_q <= 32'hA0 + {28'd0, cim_output_reg};
    assign cim_cim_output = stub_q;

    cim_controller #(.NUM_OUT(8), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_last(dout_last), .busy(busy),
        .cim_cs(cim_cs), .cim_web(cim_web), .cim_cimeb(cim_cimeb),
        .cim_partial_sum_eb(cim_partial_sum_eb),
        .cim_reset_output_reg(cim_reset_output_reg),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_cim_output(cim_cim_output)
    );

    // {cmd_ready,din_ready,dout_valid,dout_last,busy,cs,web,cimeb,psum_eb,reset_output_reg}
    function automatic logic [9:0] ctl_vec();
        return {cmd_ready, din_ready, dout_valid, dout_last, busy,
                cim_cs, cim_web, cim_cimeb, cim_partial_sum_eb, cim_reset_output_reg};
    endfunction

    localparam logic [9:0] CTL_RESET = 10'b10000_10100;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ctl_vec() !== CTL_RESET) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), CTL_RESET);
        end
        n_tests++;
        if ({cim_output_reg, cim_address, cim_input_data, dout_data} !== 100'd0) begin
            n_fail++;
            $display("FAIL reset_data: oreg=%h addr=%h data=%h dout=%h expected all 0",
                     cim_output_reg, cim_address, cim_input_data, dout_data);
        end
        next_cycle();
    endtask

    task automatic test_load();
        logic [31:0] words [2];
        logic [63:0] e;
        int          writes;
        words[0] = 32'h03020100;
        words[1] = 32'h00010203;
        writes   = 0;
        send_cmd(OP_LOAD, 32'h0, 8'd2);
        for (int i = 0; i < 2; i++) begin
            din_valid = 1'b1;
            din_data  = words[i];
            wr_q.push_back({32'(4 * i), words[i]});
            @(negedge clk);
            if (cim_web) begin
                e = wr_q.pop_front();
                writes++;
                n_tests++;
                if ({cim_address, cim_input_data} !== e) begin
                    n_fail++;
                    $display("FAIL load_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                             i, cim_address, cim_input_data, e[63:32], e[31:0]);
                end
            end
            next_cycle();
        end
        din_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (writes != 2 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL load_count: got %0d writes expected 2", writes);
        end
        wr_q.delete();
        n_tests++;
        if (ctl_vec() !== CTL_RESET) begin
            n_fail++;
            $display("FAIL load_idle: got %b expected %b", ctl_vec(), CTL_RESET);
        end
        next_cycle();
    endtask

    task automatic test_compute();
        logic [31:0] pat [3];
        logic        vld [3];
        logic [63:0] e;
        int          acc;
        pat[0] = 32'h33333333; vld[0] = 1'b1;
        pat[1] = 32'hDEADBEEF; vld[1] = 1'b0;
        pat[2] = 32'h44444444; vld[2] = 1'b1;
        acc = 0;
        send_cmd(OP_COMPUTE, 32'h40, 8'd2);
        for (int i = 0; i < 3; i++) begin
            din_valid = vld[i];
            din_data  = pat[i];
            if (vld[i]) wr_q.push_back({32'h40, pat[i]});
            @(negedge clk);
            if (!cim_cimeb) acc++;
            if (vld[i]) begin
                e = wr_q.pop_front();
                n_tests++;
                if ({cim_web, cim_cimeb, cim_partial_sum_eb, cim_address, cim_input_data} !== {3'b001, e}) begin
                    n_fail++;
                    $display("FAIL compute_beat%0d: got web=%b cimeb=%b psum=%b addr=%h data=%h expected 0/0/1 addr=%h data=%h",
                             i, cim_web, cim_cimeb, cim_partial_sum_eb, cim_address, cim_input_data, e[63:32], e[31:0]);
                end
            end else begin
                n_tests++;
                if ({din_ready, cim_cimeb, cim_partial_sum_eb, busy} !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL compute_gap: got ready=%b cimeb=%b psum=%b busy=%b expected 1/1/0/1",
                             din_ready, cim_cimeb, cim_partial_sum_eb, busy);
                end
            end
            next_cycle();
        end
        din_valid = 1'b0;
        @(negedge clk);
        if (!cim_cimeb) acc++;
        n_tests++;
        if (acc != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL compute_count: got %0d accumulate cycles busy=%b expected 2 busy=0", acc, busy);
        end
        next_cycle();
    endtask

    task automatic test_read(input logic toggle);
        logic [32:0] e;
        logic [32:0] held;
        logic        held_vld;
        int          beats;
        int          cyc;
        int          stalls;
        beats    = 0;
        cyc      = 0;
        stalls   = 0;
        held     = '0;
        held_vld = 1'b0;
        for (int k = 0; k < 8; k++)
            rd_q.push_back({(k == 7), 32'hA0 + 32'(k)});
        dout_ready = 1'b1;
        send_cmd(OP_READ, 32'h0, 8'd0);
        while (rd_q.size() != 0 && cyc < 200) begin
            dout_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (dout_valid) begin
                n_tests++;
                if (cim_output_reg !== 4'(beats)) begin
                    n_fail++;
                    $display("FAIL read_oreg: got %0d expected %0d", cim_output_reg, beats);
                end
                if (held_vld) begin
                    n_tests++;
                    if ({dout_last, dout_data} !== held) begin
                        n_fail++;
                        $display("FAIL read_stable: got %h expected %h", {dout_last, dout_data}, held);
                    end
                end
                if (dout_ready) begin
                    e = rd_q.pop_front();
                    n_tests++;
                    if ({dout_last, dout_data} !== e) begin
                        n_fail++;
                        $display("FAIL read_beat%0d: got last=%b data=%h expected last=%b data=%h",
                                 beats, dout_last, dout_data, e[32], e[31:0]);
                    end
                    beats++;
                    held_vld = 1'b0;
                end else begin
                    stalls++;
                    held     = {dout_last, dout_data};
                    held_vld = 1'b1;
                end
            end
            next_cycle();
            cyc++;
        end
        n_tests++;
        if (rd_q.size() != 0 || (toggle && stalls == 0)) begin
            n_fail++;
            $display("FAIL read_done: got %0d beats %0d stalls expected 8 beats", beats, stalls);
        end
        rd_q.delete();
        dout_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, dout_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_idle: got busy=%b valid=%b expected 0/0", busy, dout_valid);
        end
        next_cycle();
    endtask

    task automatic test_clear();
        int pulses;
        pulses = 0;
        send_cmd(OP_CLEAR, 32'h0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cim_reset_output_reg) pulses++;
            next_cycle();
        end
        n_tests++;
        if (pulses != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pulse: got %0d pulses busy=%b expected 1 busy=0", pulses, busy);
        end
    endtask

    task automatic test_load_len0();
        int busy_cyc;
        int webs;
        busy_cyc = 0;
        webs     = 0;
        send_cmd(OP_LOAD, 32'h100, 8'd0);
        din_valid = 1'b1;
        din_data  = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (cim_web || din_ready) webs++;
            next_cycle();
        end
        din_valid = 1'b0;
        n_tests++;
        if (busy_cyc != 1 || webs != 0) begin
            n_fail++;
            $display("FAIL load_len0: got busy=%0d web/ready=%0d expected 1 and 0", busy_cyc, webs);
        end
    endtask

    task automatic test_rst_mid_compute();
        send_cmd(OP_COMPUTE, 32'h80, 8'd4);
        din_valid = 1'b1;
        din_data  = 32'h11111111;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ctl_vec() !== CTL_RESET) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got %b expected %b", ctl_vec(), CTL_RESET);
        end
        n_tests++;
        if ({cim_output_reg, cim_address, cim_input_data, dout_data} !== 100'd0) begin
            n_fail++;
            $display("FAIL rst_mid_data: oreg=%h addr=%h data=%h dout=%h expected all 0",
                     cim_output_reg, cim_address, cim_input_data, dout_data);
        end
        next_cycle();
        din_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_addr   = 32'd0;
        cmd_len    = 8'd0;
        din_valid  = 1'b0;
        din_data   = 32'd0;
        dout_ready = 1'b1;
        test_reset();
        test_load();
        test_compute();
        test_read(1'b0);
        test_read(1'b1);
        test_clear();
        test_load_len0();
        test_rst_mid_compute();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_controller.md
# cim_controller

Command-driven sequencer that acts as the initiator on the Basic_GeMM_CIM macro port. Accepts LOAD/COMPUTE/READ/CLEAR commands from the core-side, streams weight words and input vectors into the macro, and returns output registers as a valid/ready result stream. Sits between the RISC-V PIM command decoder and one CIM macro instance.

## Interface
- NUM_OUT, 8, output registers read by READ (1..16)
- READ_LAT, 1, cycles from cim_output_reg change to valid cim_cim_output (1..3)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  command handshake, transfer when both high
- cmd_op  in  2  0 LOAD, 1 COMPUTE, 2 READ, 3 CLEAR
- cmd_addr  in  32  LOAD start byte address; COMPUTE row address
- cmd_len  in  8  LOAD words / COMPUTE vectors; ignored by READ, CLEAR
- din_valid / din_ready  in/out  1  data stream handshake
- din_data  in  32  weight word (LOAD) or input vector (COMPUTE)
- dout_valid / dout_ready  out/in  1  result handshake
- dout_data  out  32  output register contents
- dout_last  out  1  high on final READ beat
- busy  out  1  state != IDLE
- cim_cs, cim_web, cim_cimeb, cim_partial_sum_eb, cim_reset_output_reg  out  1  macro controls
- cim_output_reg  out  4  output register select
- cim_address, cim_input_data  out  32  macro address / data
- cim_cim_output  in  32  selected output register from macro

## Operation
- States: IDLE, LOAD, COMPUTE, CLEAR, READ_SEL, READ_WAIT, READ_OUT.
- cmd_ready = (state==IDLE); din_ready high only in LOAD/COMPUTE with beats remaining.
- Idle bus: cs=1, web=0, cimeb=1, partial_sum_eb=0, reset_output_reg=0.
- LOAD: per accepted din beat i, same cycle drive web=1, address=cmd_addr+4*i, input_data=din_data. No beat: web=0. After cmd_len beats -> IDLE.
- COMPUTE: per accepted beat drive web=0, cimeb=0, partial_sum_eb=1, address=cmd_addr, input_data=din_data. Stall cycles: cimeb=1, partial_sum_eb=0 (no accumulation). After cmd_len beats -> IDLE.
- CLEAR: one cycle reset_output_reg=1 -> IDLE.
- READ: for k=0..NUM_OUT-1: READ_SEL drives output_reg=k; READ_WAIT holds READ_LAT cycles; READ_OUT registers cim_cim_output into dout_data, dout_valid=1, holds until dout_ready; dout_last when k==NUM_OUT-1; then next k or IDLE.
- cmd_len==0 for LOAD/COMPUTE: one cycle in state, no macro activity, back to IDLE.
- Address arithmetic wraps modulo 2^32.

## Timing
- Reset values: cmd_ready=1 (IDLE), din_ready=0, dout_valid=0, dout_data=0, dout_last=0, busy=0, cim_cs=1, cim_web=0, cim_cimeb=1, cim_partial_sum_eb=0, cim_reset_output_reg=0, cim_output_reg=0, cim_address=0, cim_input_data=0.
- Command accepted at edge N -> state change visible cycle N+1.
- LOAD/COMPUTE: macro controls are combinational from din handshake in that cycle; one word/vector per cycle at full throughput.
- READ latency per output: 1 (SEL) + READ_LAT + 1 (OUT) cycles minimum; backpressure extends OUT only, output_reg stable throughout.
- dout_data/dout_last stable while dout_valid && !dout_ready.
- rst mid-operation: next cycle all reset values, pending beats dropped, no further macro writes.

## Configuration
- CIM_CTRL_PERF_EN defined: adds outputs perf_busy  out 32 (cycles busy==1) and perf_stall  out 32 (LOAD/COMPUTE cycles without din beat plus READ_OUT cycles with dout_valid && !dout_ready); saturate at 0xFFFFFFFF, zeroed by rst or CLEAR.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package cim_ctrl_pkg: cmd_op encodings, state enum, idle-bus control constants.
- One sub-module natural: cim_ctrl_readout (READ_SEL/WAIT/OUT sequencing and dout skid-hold).

## Test plan
Bench uses a behavioural macro stub with cim_cim_output = 0xA0+output_reg after READ_LAT.
- LOAD addr 0 len 2, din 0x03020100, 0x00010203 back-to-back -> two web=1 cycles, address 0 then 4, data matches, then IDLE.
- COMPUTE len 2 with din 0x33333333, gap cycle, 0x44444444 -> exactly two cycles cimeb=0/partial_sum_eb=1, gap cycle cimeb=1/partial_sum_eb=0.
- READ with dout_ready=1 -> 8 beats 0xA0..0xA7, dout_last only on 0xA7, output_reg 0..7 in order.
- READ with dout_ready toggling 1/0 -> same 8 values, none lost or duplicated, data stable during stalls.
- CLEAR -> single-cycle cim_reset_output_reg=1; LOAD len 0 -> busy one cycle, no web.
- rst asserted mid-COMPUTE -> next cycle all reset values, cmd_ready=1; with CIM_CTRL_PERF_EN, counters 0.
